eth_tx_frame_arbiter: RTL and testbench

Frame-atomic round-robin arbiter that shares the single 8-bit AXI-stream input of the GMII frame transmitter between up to PORTS byte-stream sources, e.g. the CPU TX buffer and a pause-frame generator. A grant is held from the first byte to the tlast handshake, so frames never interleave. It also enforces a maximum frame length by truncating oversize frames with tuser set, and gates new grants with a transmit-enable input.

---
 rtl/eth_tx_frame_arbiter.sv | 156 +++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter feeding a single 8-bit AXI-stream GMII transmitter input.
// Oversize frames are cut at MAX_FRAME_LENGTH with tlast/tuser forced, and the rest of the source frame is discarded.
`timescale 1ns/1ps

module eth_tx_frame_arbiter #(
    parameter int PORTS            = 2,
    parameter int MAX_FRAME_LENGTH = 1518
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PORTS*8-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]   s_axis_tvalid,
    output logic [PORTS-1:0]   s_axis_tready,
    input  logic [PORTS-1:0]   s_axis_tlast,
    input  logic [PORTS-1:0]   s_axis_tuser,
    output logic [7:0]         m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser,
    input  logic               tx_enable,
    output logic               busy,
    output logic [1:0]         grant_id,
    output logic               frame_done,
    output logic               frame_trunc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } state_t;

    localparam logic [15:0] LIMIT_CNT = 16'(MAX_FRAME_LENGTH - 1);
    localparam logic [1:0]  LAST_PORT = 2'(PORTS - 1);

    state_t      state, state_next;
    logic [1:0]  grant, grant_next;
    logic [1:0]  last_grant, last_grant_next;
    logic [15:0] byte_cnt, byte_cnt_next;

    logic [7:0]       g_data;
    logic             g_valid;
    logic             g_last;
    logic             g_user;
    logic [PORTS-1:0] g_mask;
    logic             req_found;
    logic [1:0]       req_port;
    logic             at_limit;

    // Source signals of the currently granted port.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_user  = 1'b0;
        g_mask  = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant == 2'(i)) begin
                g_data    = s_axis_tdata[8*i +: 8];
                g_valid   = s_axis_tvalid[i];
                g_last    = s_axis_tlast[i];
                g_user    = s_axis_tuser[i];
                g_mask[i] = 1'b1;
            end
        end
    end

    // Round-robin: first requester scanning last_grant+1, last_grant+2, ... modulo PORTS.
    always_comb begin
        req_found = 1'b0;
        req_port  = '0;
        for (int k = 1; k <= PORTS; k++) begin
            for (int i = 0; i < PORTS; i++) begin
                if (!req_found && (i == (int'(last_grant) + k) % PORTS) && s_axis_tvalid[i]) begin
                    req_found = 1'b1;
                    req_port  = 2'(i);
                end
            end
        end
    end

    assign at_limit = (byte_cnt == LIMIT_CNT);

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        byte_cnt_next   = byte_cnt;
        s_axis_tready   = '0;
        m_axis_tdata    = '0;
        m_axis_tvalid   = 1'b0;
        m_axis_tlast    = 1'b0;
        m_axis_tuser    = 1'b0;
        frame_done      = 1'b0;
        frame_trunc     = 1'b0;

        unique case (state)
            IDLE: begin
                if (tx_enable && req_found) begin
                    grant_next    = req_port;
                    byte_cnt_next = '0;
                    state_next    = ACTIVE;
                end
            end
            ACTIVE: begin
                // The truncation override only ever touches the byte at the length limit.
                m_axis_tdata  = g_data;
                m_axis_tvalid = g_valid;
                m_axis_tlast  = g_last || at_limit;
                m_axis_tuser  = g_user || (at_limit && !g_last);
                s_axis_tready = g_mask & {PORTS{m_axis_tready}};
                if (g_valid && m_axis_tready) begin
                    byte_cnt_next = byte_cnt + 16'd1;
                    if (g_last) begin
                        frame_done      = 1'b1;
                        last_grant_next = grant;
                        state_next      = IDLE;
                    end else if (at_limit) begin
                        frame_done  = 1'b1;
                        frame_trunc = 1'b1;
                        state_next  = DROP;
                    end
                end
            end
            DROP: begin
                s_axis_tready = g_mask;
                if (g_valid && g_last) begin
                    last_grant_next = grant;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_PORT;
            byte_cnt   <= '0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            byte_cnt   <= byte_cnt_next;
        end
    end

    assign busy     = (state != IDLE);
    assign grant_id = grant;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Scoreboard bench for eth_tx_frame_arbiter: frames are expanded into expected output beats per port,
// and a monitor pops and compares on every transmitter handshake.
`timescale 1ns/1ps

module tb_eth_tx_frame_arbiter;

    localparam int PORTS   = 3;
    localparam int MAX_LEN = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } src_beat_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       trunc;
    } exp_beat_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [PORTS*8-1:0] s_axis_tdata;
    logic [PORTS-1:0]   s_axis_tvalid;
    logic [PORTS-1:0]   s_axis_tready;
    logic [PORTS-1:0]   s_axis_tlast;
    logic [PORTS-1:0]   s_axis_tuser;
    logic [7:0]         m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               m_axis_tlast;
    logic               m_axis_tuser;
    logic               tx_enable;
    logic               busy;
    logic [1:0]         grant_id;
    logic               frame_done;
    logic               frame_trunc;

    eth_tx_frame_arbiter #(
        .PORTS            (PORTS),
        .MAX_FRAME_LENGTH (MAX_LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .tx_enable     (tx_enable),
        .busy          (busy),
        .grant_id      (grant_id),
        .frame_done    (frame_done),
        .frame_trunc   (frame_trunc)
    );

    always #5 clk = ~clk;

    src_beat_t src_q[PORTS][$];
    exp_beat_t exp_q[PORTS][$];

    int n_checks  = 0;
    int n_fail    = 0;
    int gap_pct   = 0;
    int ready_mode = 0;
    int flush_req = 0;

    // Monitor-owned observations.
    int mon_cyc       = 0;
    int done_cnt      = 0;
    int trunc_cnt     = 0;
    int beat_cnt      = 0;
    int last_done_cyc = -1000;
    int grant_log[$];
    int gap_log[$];
    int rr_exp[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: forward the first min(len, MAX_LEN) bytes; a cut frame ends with tlast=tuser=1.
    task automatic send_frame(input int p, input int len, input bit user);
        bit trunc;
        int nfwd;
        src_beat_t sb;
        exp_beat_t eb;
        trunc = (len > MAX_LEN);
        nfwd  = trunc ? MAX_LEN : len;
        for (int i = 0; i < len; i++) begin
            sb.data = 8'($urandom);
            sb.last = (i == len - 1);
            sb.user = (i == len - 1) && user;
            src_q[p].push_back(sb);
            if (i < nfwd) begin
                eb.data  = sb.data;
                eb.last  = (i == nfwd - 1);
                eb.user  = sb.user || (trunc && (i == nfwd - 1));
                eb.trunc = trunc && (i == nfwd - 1);
                exp_q[p].push_back(eb);
            end
        end
    endtask

    // Round-robin grant order for ports that keep requesting until their frame counts run out.
    task automatic build_rr(input int start_last, input int c0, input int c1, input int c2);
        int cnt[PORTS];
        int last;
        int p;
        bit found;
        cnt[0] = c0;
        cnt[1] = c1;
        cnt[2] = c2;
        last = start_last;
        rr_exp.delete();
        for (int n = 0; n < c0 + c1 + c2; n++) begin
            found = 1'b0;
            for (int k = 1; k <= PORTS; k++) begin
                p = (last + k) % PORTS;
                if (!found && cnt[p] > 0) begin
                    rr_exp.push_back(p);
                    cnt[p]--;
                    last  = p;
                    found = 1'b1;
                end
            end
        end
    endtask

    task automatic check_rr(input int g0);
        check("rr_count", 64'(grant_log.size() - g0), 64'(rr_exp.size()));
        for (int i = 0; i < rr_exp.size(); i++) begin
            if (g0 + i < grant_log.size())
                check("rr_order", 64'(grant_log[g0 + i]), 64'(rr_exp[i]));
        end
    endtask

    function automatic bit all_drained();
        bit d = !busy;
        for (int p = 0; p < PORTS; p++)
            if (src_q[p].size() != 0 || exp_q[p].size() != 0) d = 1'b0;
        return d;
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        while (n < budget && !all_drained()) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_budget", 64'(n < budget), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_beats(input int b0, input int nb, input int budget);
        int n = 0;
        while (n < budget && (beat_cnt - b0) < nb) begin
            @(negedge clk);
            n++;
        end
        check("beats_in_budget", 64'(n < budget), 64'd1);
    endtask

    // Source and transmitter-ready driver: inputs change 1 time unit after the rising edge.
    initial begin : driver
        bit        hs[PORTS];
        int        flush_seen = 0;
        src_beat_t b;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            for (int p = 0; p < PORTS; p++) hs[p] = s_axis_tvalid[p] && s_axis_tready[p];
            @(posedge clk);
            #1;
            if (flush_seen != flush_req) begin
                flush_seen = flush_req;
                for (int p = 0; p < PORTS; p++) begin
                    src_q[p].delete();
                    hs[p] = 1'b0;
                end
                s_axis_tvalid = '0;
            end
            for (int p = 0; p < PORTS; p++) begin
                if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (hs[p] || !s_axis_tvalid[p]) begin
                    if (src_q[p].size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                        b = src_q[p][0];
                        s_axis_tvalid[p]         = 1'b1;
                        s_axis_tdata[8*p +: 8]   = b.data;
                        s_axis_tlast[p]          = b.last;
                        s_axis_tuser[p]          = b.user;
                    end else begin
                        s_axis_tvalid[p] = 1'b0;
                    end
                end
            end
            case (ready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = ($urandom_range(0, 99) < 70);
            endcase
        end
    end

    // Monitor: pops the expected beat of the granted port on every transmitter handshake.
    initial begin : monitor
        exp_beat_t        e;
        int               g;
        bit               mid_frame = 1'b0;
        int               cur_port  = 0;
        logic [PORTS-1:0] other;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (rst) begin
                mid_frame = 1'b0;
                continue;
            end
            g = int'(grant_id);
            other = '1;
            other[g] = 1'b0;
            check("tready_other_ports", 64'(s_axis_tready & other), 64'd0);
            if (m_axis_tvalid) check("tready_mirror", 64'(s_axis_tready[g]), 64'(m_axis_tready));
            if (m_axis_tvalid && m_axis_tready) begin
                if (mid_frame && g != cur_port) check("interleave", 64'(g), 64'(cur_port));
                if (!mid_frame) begin
                    grant_log.push_back(g);
                    gap_log.push_back(mon_cyc - last_done_cyc);
                    mid_frame = 1'b1;
                    cur_port  = g;
                end
                check("beat_expected", 64'(exp_q[g].size() > 0), 64'd1);
                if (exp_q[g].size() > 0) begin
                    e = exp_q[g].pop_front();
                    check("beat_data_last_user", 64'({m_axis_tdata, m_axis_tlast, m_axis_tuser}),
                          64'({e.data, e.last, e.user}));
                    check("frame_done", 64'(frame_done), 64'(e.last));
                    check("frame_trunc", 64'(frame_trunc), 64'(e.trunc));
                    if (e.last) begin
                        mid_frame     = 1'b0;
                        last_done_cyc = mon_cyc;
                    end
                end
                beat_cnt++;
            end else begin
                check("no_pulse_without_beat", 64'({frame_done, frame_trunc}), 64'd0);
            end
            if (frame_done) done_cnt++;
            if (frame_trunc) trunc_cnt++;
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int d0, t0, b0, g0, gp0, n;
        rst       = 1'b1;
        tx_enable = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({s_axis_tready, m_axis_tvalid, m_axis_tdata, busy, grant_id, frame_done, frame_trunc}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single 60-byte frame on port 0, first byte one cycle after tvalid.
        @(posedge clk);
        #2;
        d0 = done_cnt;
        t0 = trunc_cnt;
        send_frame(0, 60, 1'b0);
        n = 0;
        while (n < 10 && !s_axis_tvalid[0]) begin
            @(negedge clk);
            n++;
        end
        check("src_valid_seen", 64'(s_axis_tvalid[0]), 64'd1);
        check("arb_cycle_no_output", 64'({m_axis_tvalid, busy}), 64'd0);
        @(negedge clk);
        check("first_byte_latency", 64'({m_axis_tvalid, busy, grant_id}), 64'({1'b1, 1'b1, 2'd0}));
        wait_idle(500);
        check("single_done_count", 64'(done_cnt - d0), 64'd1);
        check("single_trunc_count", 64'(trunc_cnt - t0), 64'd0);
        check("grant_id_holds", 64'(grant_id), 64'd0);

        // Contention: three frames each on ports 0 and 1, alternating with one idle cycle between.
        @(posedge clk);
        #2;
        g0  = grant_log.size();
        gp0 = gap_log.size();
        for (int k = 0; k < 3; k++) begin
            send_frame(0, int'($urandom_range(5, 20)), 1'b0);
            send_frame(1, int'($urandom_range(5, 20)), 1'b0);
        end
        build_rr(0, 3, 3, 0);
        wait_idle(1000);
        check_rr(g0);
        for (int i = 1; i < 6; i++)
            if (gp0 + i < gap_log.size()) check("one_idle_gap", 64'(gap_log[gp0 + i]), 64'd2);

        // Backpressure: ready toggles every cycle while port 0 also waits.
        ready_mode = 1;
        @(posedge clk);
        #2;
        send_frame(1, 20, 1'b1);
        send_frame(0, 10, 1'b0);
        wait_idle(1000);
        ready_mode = 0;

        // Truncation and length boundaries.
        @(posedge clk);
        #2;
        d0 = done_cnt;
        t0 = trunc_cnt;
        b0 = beat_cnt;
        send_frame(1, 100, 1'b0);
        wait_idle(1000);
        check("trunc_beats", 64'(beat_cnt - b0), 64'(MAX_LEN));
        check("trunc_done", 64'(done_cnt - d0), 64'd1);
        check("trunc_pulse", 64'(trunc_cnt - t0), 64'd1);
        t0 = trunc_cnt;
        send_frame(0, MAX_LEN, 1'b1);
        wait_idle(1000);
        check("exact_max_no_trunc", 64'(trunc_cnt - t0), 64'd0);
        send_frame(2, MAX_LEN + 1, 1'b0);
        send_frame(2, 1, 1'b1);
        wait_idle(1000);
        check("max_plus_one_trunc", 64'(trunc_cnt - t0), 64'd1);

        // tx_enable gating.
        @(posedge clk);
        #2;
        b0 = beat_cnt;
        send_frame(0, 30, 1'b0);
        wait_beats(b0, 10, 200);
        @(posedge clk);
        #2;
        tx_enable = 1'b0;
        send_frame(1, 8, 1'b0);
        n = 0;
        while (n < 200 && (exp_q[0].size() != 0 || busy)) begin
            @(negedge clk);
            n++;
        end
        check("gated_frame_completes", 64'(exp_q[0].size()), 64'd0);
        repeat (5) begin
            @(negedge clk);
            check("gated_request_pending", 64'(s_axis_tvalid[1]), 64'd1);
            check("gated_no_grant", 64'({busy, s_axis_tready, m_axis_tvalid}), 64'd0);
        end
        @(posedge clk);
        #1 tx_enable = 1'b1;
        @(negedge clk);
        check("enable_arb_cycle", 64'(busy), 64'd0);
        @(negedge clk);
        check("enable_grant", 64'({busy, grant_id, m_axis_tvalid}), 64'({1'b1, 2'd1, 1'b1}));
        wait_idle(500);

        // Reset mid-frame.
        @(posedge clk);
        #2;
        b0 = beat_cnt;
        send_frame(0, 30, 1'b0);
        wait_beats(b0, 9, 200);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        tx_enable = 1'b0;
        #1 flush_req++;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_mid_frame", 64'({s_axis_tready, m_axis_tvalid, busy}), 64'd0);
        for (int p = 0; p < PORTS; p++) exp_q[p].delete();
        @(posedge clk);
        #2 tx_enable = 1'b1;

        // After reset, port 0 beats port 2 because last_grant restarts at PORTS-1.
        g0 = grant_log.size();
        send_frame(2, 6, 1'b0);
        send_frame(0, 6, 1'b0);
        build_rr(PORTS - 1, 1, 0, 1);
        wait_idle(500);
        check_rr(g0);

        // Randomised traffic with source gaps and random transmitter backpressure.
        gap_pct    = 20;
        ready_mode = 2;
        @(posedge clk);
        #2;
        d0 = done_cnt;
        for (int k = 0; k < 40; k++)
            send_frame(int'($urandom_range(0, PORTS - 1)), int'($urandom_range(1, 90)), 1'($urandom));
        wait_idle(30000);
        check("random_done_count", 64'(done_cnt - d0), 64'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
